lsu_memctl: RTL and testbench

LSU_MEMCTL -- requirements
Module: lsu_memctl

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/lsu_align.sv | 64 ++++++
 rtl/lsu_memctl.sv | 165 ++++++++++++++++
 tb/tb_lsu_memctl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the load/store unit: funct3 access-size codes
// and the memory-controller FSM state type.
package riscv_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = LB;
    localparam logic [2:0] SH  = LH;
    localparam logic [2:0] SW  = LW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } lsuState_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU: alignment check, byte enables and
// store-lane replication for the incoming request, plus lane extraction and
// sign/zero extension of the returned bus word for a completed load.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addrLo,
    input  logic [31:0] wdata,
    output logic        misalign,
    output logic [3:0]  busBe,
    output logic [31:0] laneData,
    input  logic [2:0]  ldFunct3,
    input  logic [1:0]  ldOff,
    input  logic [31:0] busRdata,
    output logic [31:0] loadData
);

    logic [31:0]        shifted;
    logic signed [7:0]  ldByte;
    logic signed [15:0] ldHalf;

    // Request side: size decode; unsupported codes fall through as misaligned.
    always_comb begin
        misalign = 1'b1;
        busBe    = 4'b0000;
        laneData = wdata;
        case (funct3)
            SB, LBU: begin
                misalign = 1'b0;
                busBe    = 4'b0001 << addrLo;
                laneData = {4{wdata[7:0]}};
            end
            SH, LHU: begin
                misalign = addrLo[0];
                busBe    = 4'b0011 << addrLo;
                laneData = {2{wdata[15:0]}};
            end
            SW: begin
                misalign = (addrLo != 2'b00);
                busBe    = 4'b1111;
                laneData = wdata;
            end
            default: ;
        endcase
    end

    // Load side: move the addressed lane to bit 0, then extend by access type.
    always_comb begin
        shifted  = busRdata >> {ldOff, 3'b000};
        ldByte   = signed'(shifted[7:0]);
        ldHalf   = signed'(shifted[15:0]);
        loadData = 32'h0000_0000;
        case (ldFunct3)
            LB:      loadData = 32'(ldByte);
            LBU:     loadData = {24'h00_0000, shifted[7:0]};
            LH:      loadData = 32'(ldHalf);
            LHU:     loadData = {16'h0000, shifted[15:0]};
            LW:      loadData = shifted;
            default: loadData = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_memctl.sv
// RV32I memory-stage controller: accepts one load/store per transaction,
// registers it onto a word bus, stalls the pipeline until bus_ack and presents
// the extended load result for one cycle in DONE.
// Optional build macro LSU_TIMEOUT_EN adds an ack-wait timeout that raises
// bus_err and completes the access with rdata=0.
module lsu_memctl
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_err
);

    lsuState_t   state;
    lsuState_t   nextState;

    logic        alignMisalign;
    logic [3:0]  alignBe;
    logic [31:0] alignLane;
    logic [31:0] alignLoad;
    logic        accept;
    logic        timeoutHit;

    logic [29:0] wordAddrQ;
    logic        weQ;
    logic [3:0]  beQ;
    logic [31:0] wdataQ;
    logic [2:0]  funct3Q;
    logic [1:0]  offQ;
    logic [31:0] rdataQ;

    lsu_align uAlign (
        .funct3   (funct3),
        .addrLo   (addr[1:0]),
        .wdata    (wdata),
        .misalign (alignMisalign),
        .busBe    (alignBe),
        .laneData (alignLane),
        .ldFunct3 (funct3Q),
        .ldOff    (offQ),
        .busRdata (bus_rdata),
        .loadData (alignLoad)
    );

    assign accept = (state == IDLE) && req_valid && !alignMisalign;

`ifdef LSU_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] waitCnt;
    logic        errQ;

    assign timeoutHit = (state == WAIT) && !bus_ack && (waitCnt == TIMEOUT_LAST);
    assign bus_err    = errQ;

    // Count WAIT cycles from zero on each new transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            waitCnt <= 16'h0000;
        end else if (accept) begin
            waitCnt <= 16'h0000;
        end else if (state == WAIT) begin
            waitCnt <= waitCnt + 16'h0001;
        end
    end

    // One-cycle error pulse, visible in the DONE cycle that follows a timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            errQ <= 1'b0;
        end else begin
            errQ <= timeoutHit;
        end
    end
`else
    logic unusedTimeout;

    assign unusedTimeout = (TIMEOUT_CYCLES != 0);
    assign timeoutHit    = 1'b0;
    assign bus_err       = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and combinational pipeline-facing outputs.
    always_comb begin
        nextState = state;
        stall     = 1'b0;
        misalign  = 1'b0;
        bus_req   = 1'b0;
        rdata     = 32'h0000_0000;
        case (state)
            IDLE: begin
                stall    = accept;
                misalign = req_valid && alignMisalign;
                if (accept) begin
                    nextState = WAIT;
                end
            end
            WAIT: begin
                stall   = 1'b1;
                bus_req = 1'b1;
                if (bus_ack || timeoutHit) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                rdata     = rdataQ;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Request registers: inputs are sampled only on acceptance and held through WAIT.
    always_ff @(posedge clk) begin
        if (accept) begin
            wordAddrQ <= addr[31:2];
            weQ       <= we;
            beQ       <= alignBe;
            wdataQ    <= alignLane;
            funct3Q   <= funct3;
            offQ      <= addr[1:0];
        end
    end

    // Load result captured on the completing edge; stores and timeouts return zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdataQ <= 32'h0000_0000;
        end else if ((state == WAIT) && (nextState == DONE)) begin
            rdataQ <= (bus_ack && !weQ) ? alignLoad : 32'h0000_0000;
        end
    end

    assign bus_we    = weQ;
    assign bus_addr  = {wordAddrQ, 2'b00};
    assign bus_be    = beQ;
    assign bus_wdata = wdataQ;

endmodule

// File: tb/tb_lsu_memctl.sv
// Directed self-checking bench for lsu_memctl: reset, word/byte/half loads,
// store lane replication, misalignment, delayed ack, reset mid-transaction and
// the ack-wait timeout (build macro LSU_TIMEOUT_EN) or its absence.
module tb_lsu_memctl;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        misalign;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] expAddr;
        logic [3:0]  expBe;
        logic [31:0] expData;
    } vec_t;

    vec_t ldVecs [7];
    vec_t stVecs [4];

    always #5 clk = ~clk;

    lsu_memctl #(.TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .we        (we),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .misalign  (misalign),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .bus_err   (bus_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        req_valid = 1'b0;
        we        = 1'b0;
        funct3    = LW;
        addr      = 32'hFFFF_FFFC;
        wdata     = 32'h5555_5555;
    endtask

    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        we        = w;
        funct3    = f3;
        addr      = a;
        wdata     = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL reset_bus_req got %b want 0", bus_req); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got %b want 0", stall); end
        checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL reset_misalign got %b want 0", misalign); end
        checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL reset_bus_err got %b want 0", bus_err); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got %h want 0", rdata); end
    endtask

    task automatic test_lw_basic();
        int stallCnt = 0;
        step();
        issue(1'b0, LW, 32'h0000_0100, 32'h0);
        #1;
        if (stall === 1'b1) stallCnt++;
        checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL lw_accept_bus_req got %b want 0", bus_req); end
        step();
        idleInputs();
        bus_ack   = 1'b1;
        bus_rdata = 32'hDEAD_BEEF;
        #1;
        if (stall === 1'b1) stallCnt++;
        checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL lw_wait_bus_req got %b want 1", bus_req); end
        checks++; if (bus_addr !== 32'h0000_0100) begin failures++; $display("FAIL lw_bus_addr got %h want 00000100", bus_addr); end
        checks++; if (bus_be !== 4'b1111) begin failures++; $display("FAIL lw_bus_be got %b want 1111", bus_be); end
        checks++; if (bus_we !== 1'b0) begin failures++; $display("FAIL lw_bus_we got %b want 0", bus_we); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL lw_wait_rdata got %h want 0", rdata); end
        step();
        bus_ack = 1'b0;
        #1;
        if (stall === 1'b1) stallCnt++;
        checks++; if (rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lw_done_rdata got %h want deadbeef", rdata); end
        checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL lw_done_bus_req got %b want 0", bus_req); end
        checks++; if (stallCnt !== 2) begin failures++; $display("FAIL lw_stall_cycles got %0d want 2", stallCnt); end
        step();
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL lw_after_rdata got %h want 0", rdata); end
    endtask

    task automatic test_load_ext();
        ldVecs[0] = '{LB,  32'h0000_0203, 32'h80AA_BBCC, 32'h0000_0200, 4'b1000, 32'hFFFF_FF80};
        ldVecs[1] = '{LBU, 32'h0000_0203, 32'h80AA_BBCC, 32'h0000_0200, 4'b1000, 32'h0000_0080};
        ldVecs[2] = '{LH,  32'h0000_0102, 32'h9ABC_1234, 32'h0000_0100, 4'b1100, 32'hFFFF_9ABC};
        ldVecs[3] = '{LHU, 32'h0000_0102, 32'h9ABC_1234, 32'h0000_0100, 4'b1100, 32'h0000_9ABC};
        ldVecs[4] = '{LB,  32'h0000_0101, 32'h0000_F37F, 32'h0000_0100, 4'b0010, 32'hFFFF_FFF3};
        ldVecs[5] = '{LH,  32'h0000_0100, 32'h1234_7FFF, 32'h0000_0100, 4'b0011, 32'h0000_7FFF};
        ldVecs[6] = '{LW,  32'h0000_0208, 32'h8000_0001, 32'h0000_0208, 4'b1111, 32'h8000_0001};
        for (int i = 0; i < 7; i++) begin
            issue(1'b0, ldVecs[i].f3, ldVecs[i].a, 32'h0);
            #1;
            checks++; if (stall !== 1'b1) begin failures++; $display("FAIL ld%0d_accept_stall got %b want 1", i, stall); end
            step();
            idleInputs();
            bus_ack   = 1'b1;
            bus_rdata = ldVecs[i].d;
            #1;
            checks++; if (bus_addr !== ldVecs[i].expAddr) begin failures++; $display("FAIL ld%0d_bus_addr got %h want %h", i, bus_addr, ldVecs[i].expAddr); end
            checks++; if (bus_be !== ldVecs[i].expBe) begin failures++; $display("FAIL ld%0d_bus_be got %b want %b", i, bus_be, ldVecs[i].expBe); end
            step();
            bus_ack   = 1'b0;
            bus_rdata = 32'h0;
            #1;
            checks++; if (rdata !== ldVecs[i].expData) begin failures++; $display("FAIL ld%0d_rdata got %h want %h", i, rdata, ldVecs[i].expData); end
            checks++; if (stall !== 1'b0) begin failures++; $display("FAIL ld%0d_done_stall got %b want 0", i, stall); end
            step();
        end
    endtask

    task automatic test_store();
        stVecs[0] = '{SH, 32'h0000_0102, 32'h1234_ABCD, 32'h0000_0100, 4'b1100, 32'hABCD_ABCD};
        stVecs[1] = '{SB, 32'h0000_0101, 32'h0000_00A5, 32'h0000_0100, 4'b0010, 32'hA5A5_A5A5};
        stVecs[2] = '{SW, 32'h0000_0104, 32'hCAFE_F00D, 32'h0000_0104, 4'b1111, 32'hCAFE_F00D};
        stVecs[3] = '{SB, 32'h0000_03FF, 32'h1122_3344, 32'h0000_03FC, 4'b1000, 32'h4444_4444};
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, stVecs[i].f3, stVecs[i].a, stVecs[i].d);
            step();
            idleInputs();
            bus_ack   = 1'b1;
            bus_rdata = 32'hFFFF_FFFF;
            #1;
            checks++; if (bus_we !== 1'b1) begin failures++; $display("FAIL st%0d_bus_we got %b want 1", i, bus_we); end
            checks++; if (bus_addr !== stVecs[i].expAddr) begin failures++; $display("FAIL st%0d_bus_addr got %h want %h", i, bus_addr, stVecs[i].expAddr); end
            checks++; if (bus_be !== stVecs[i].expBe) begin failures++; $display("FAIL st%0d_bus_be got %b want %b", i, bus_be, stVecs[i].expBe); end
            checks++; if (bus_wdata !== stVecs[i].expData) begin failures++; $display("FAIL st%0d_bus_wdata got %h want %h", i, bus_wdata, stVecs[i].expData); end
            step();
            bus_ack = 1'b0;
            #1;
            checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL st%0d_done_rdata got %h want 0", i, rdata); end
            step();
        end
    endtask

    task automatic test_misalign();
        logic [2:0]  mf3 [7];
        logic [31:0] ma  [7];
        mf3 = '{LW, LW, LH, LHU, 3'b011, 3'b110, 3'b111};
        ma  = '{32'h101, 32'h102, 32'h103, 32'h101, 32'h100, 32'h100, 32'h100};
        for (int i = 0; i < 7; i++) begin
            issue(1'b0, mf3[i], ma[i], 32'h0);
            #1;
            checks++; if (misalign !== 1'b1) begin failures++; $display("FAIL mis%0d_pulse got %b want 1", i, misalign); end
            checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mis%0d_stall got %b want 0", i, stall); end
            checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL mis%0d_rdata got %h want 0", i, rdata); end
            step();
            idleInputs();
            #1;
            checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL mis%0d_bus_req got %b want 0", i, bus_req); end
            checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL mis%0d_clear got %b want 0", i, misalign); end
            step();
        end
    endtask

    task automatic test_delayed_ack();
        int stallCnt = 0;
        int holdBad  = 0;
        issue(1'b0, LW, 32'h0000_0300, 32'h0);
        #1;
        if (stall === 1'b1) stallCnt++;
        step();
        for (int w = 1; w <= 5; w++) begin
            issue(1'b1, LB, 32'h0000_0777, 32'h7777_7777);
            bus_ack   = (w == 5);
            bus_rdata = (w == 5) ? 32'h0BAD_F00D : 32'h1111_1111;
            #1;
            if (stall === 1'b1) stallCnt++;
            if (bus_req !== 1'b1 || bus_addr !== 32'h0000_0300 || bus_be !== 4'b1111 || bus_we !== 1'b0) holdBad++;
            step();
        end
        idleInputs();
        bus_ack = 1'b0;
        #1;
        checks++; if (holdBad !== 0) begin failures++; $display("FAIL delay_hold got %0d bad cycles want 0", holdBad); end
        checks++; if (stallCnt !== 6) begin failures++; $display("FAIL delay_stall_cycles got %0d want 6", stallCnt); end
        checks++; if (rdata !== 32'h0BAD_F00D) begin failures++; $display("FAIL delay_rdata got %h want 0badf00d", rdata); end
        step();
        checks++; if (rdata !== 32'h0 || bus_req !== 1'b0) begin failures++; $display("FAIL delay_single_done got rdata=%h bus_req=%b want 0/0", rdata, bus_req); end
    endtask

    task automatic test_reset_mid_wait();
        issue(1'b0, LW, 32'h0000_0400, 32'h0);
        step();
        idleInputs();
        #1;
        checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL rstwait_bus_req got %b want 1", bus_req); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checks++; if (bus_req !== 1'b0 || stall !== 1'b0 || rdata !== 32'h0) begin failures++; $display("FAIL rstwait_idle got req=%b stall=%b rdata=%h want 0/0/0", bus_req, stall, rdata); end
        bus_ack   = 1'b1;
        bus_rdata = 32'hFEED_FACE;
        step();
        bus_ack = 1'b0;
        #1;
        checks++; if (bus_req !== 1'b0 || stall !== 1'b0 || rdata !== 32'h0) begin failures++; $display("FAIL stray_ack got req=%b stall=%b rdata=%h want 0/0/0", bus_req, stall, rdata); end
        step();
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL stray_ack_later got rdata=%h want 0", rdata); end
    endtask

    task automatic test_timeout();
`ifdef LSU_TIMEOUT_EN
        int waitBad = 0;
        issue(1'b0, LW, 32'h0000_0500, 32'h0);
        #1;
        step();
        for (int w = 1; w <= 4; w++) begin
            idleInputs();
            bus_ack   = 1'b0;
            bus_rdata = 32'hFFFF_FFFF;
            #1;
            if (bus_req !== 1'b1 || bus_err !== 1'b0) waitBad++;
            step();
        end
        #1;
        checks++; if (waitBad !== 0) begin failures++; $display("FAIL to_wait got %0d bad cycles want 0", waitBad); end
        checks++; if (bus_err !== 1'b1) begin failures++; $display("FAIL to_bus_err got %b want 1", bus_err); end
        checks++; if (bus_req !== 1'b0 || rdata !== 32'h0 || stall !== 1'b0) begin failures++; $display("FAIL to_done got req=%b rdata=%h stall=%b want 0/0/0", bus_req, rdata, stall); end
        step();
        checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL to_err_pulse got %b want 0", bus_err); end
        issue(1'b0, LW, 32'h0000_0600, 32'h0);
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL to_idle_accept got stall=%b want 1", stall); end
        step();
        idleInputs();
        bus_ack   = 1'b1;
        bus_rdata = 32'h1357_9BDF;
        step();
        bus_ack = 1'b0;
        #1;
        checks++; if (rdata !== 32'h1357_9BDF) begin failures++; $display("FAIL to_next_rdata got %h want 13579bdf", rdata); end
        step();
`else
        int waitBad = 0;
        issue(1'b0, LW, 32'h0000_0500, 32'h0);
        #1;
        step();
        for (int w = 1; w <= 20; w++) begin
            idleInputs();
            bus_ack = 1'b0;
            #1;
            if (bus_req !== 1'b1 || bus_err !== 1'b0 || stall !== 1'b1) waitBad++;
            step();
        end
        checks++; if (waitBad !== 0) begin failures++; $display("FAIL noto_wait got %0d bad cycles want 0", waitBad); end
        bus_ack   = 1'b1;
        bus_rdata = 32'h1357_9BDF;
        step();
        bus_ack = 1'b0;
        #1;
        checks++; if (rdata !== 32'h1357_9BDF || bus_err !== 1'b0) begin failures++; $display("FAIL noto_done got rdata=%h err=%b want 13579bdf/0", rdata, bus_err); end
        step();
`endif
    endtask

    initial begin
        idleInputs();
        reset     = 1'b1;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        test_reset();
        test_lw_basic();
        test_load_ext();
        test_store();
        test_misalign();
        test_delayed_ack();
        test_reset_mid_wait();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
